// File: rtl/out_src_seq_pkg.sv
// Shared FSM encoding and parameter defaults for the output-source switch sequencer.
package out_src_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_MUTE  = 2'd2
    } state_e;

    localparam int   MUTE_FRAMES_DEF = 2;
    localparam int   VS_TIMEOUT_DEF  = 1048576;
    localparam logic VS_ACTIVE_DEF   = 1'b0;

    function automatic int min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/vs_edge_det.sv
// Vsync leading-edge detector: one registered previous sample, combinational compare.
module vs_edge_det #(
    parameter logic VS_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic lead_edge
);

    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= vsync;
    end

    assign lead_edge = (prev_q != VS_ACTIVE) && (vsync == VS_ACTIVE);

endmodule

// File: rtl/out_src_seq.sv
// Output source switch sequencer: drains the old source to a frame boundary, then
// holds the output muted for a number of new-source frames before releasing it.
module out_src_seq
    import out_src_seq_pkg::*;
#(
    parameter int   MUTE_FRAMES = MUTE_FRAMES_DEF,
    parameter int   VS_TIMEOUT  = VS_TIMEOUT_DEF,
    parameter logic VS_ACTIVE   = VS_ACTIVE_DEF
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       sel_req,
    input  logic       vsync_sc,
    input  logic       vsync_vg,
    output logic       src_sel,
    output logic       mute,
    output logic       vg_reset,
    output logic       busy,
    output logic       timeout_flag,
    output logic [7:0] switch_cnt
);

    localparam int TMR_W = min1($clog2(VS_TIMEOUT));
    localparam int FRM_W = min1($clog2(MUTE_FRAMES + 1));
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(VS_TIMEOUT - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(MUTE_FRAMES);

    state_e           state_q, state_d;
    logic             sync1_q, sel_s_q;
    logic             src_sel_q, src_sel_d;
    logic             mute_q, mute_d;
    logic             busy_q, busy_d;
    logic             vg_reset_q, vg_reset_d;
    logic             tflag_q, tflag_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [FRM_W-1:0] frame_q, frame_d, frame_inc;
    logic             edge_sc, edge_vg, cur_edge;

    vs_edge_det #(.VS_ACTIVE(VS_ACTIVE)) u_edge_sc (
        .clk(pclk), .rst(reset), .vsync(vsync_sc), .lead_edge(edge_sc)
    );
    vs_edge_det #(.VS_ACTIVE(VS_ACTIVE)) u_edge_vg (
        .clk(pclk), .rst(reset), .vsync(vsync_vg), .lead_edge(edge_vg)
    );

    // In DRAIN this is the old source's edge; in MUTE src_sel already points at the new one.
    assign cur_edge = src_sel_q ? edge_sc : edge_vg;

    always_comb begin
        state_d   = state_q;
        src_sel_d = src_sel_q;
        mute_d    = mute_q;
        busy_d    = busy_q;
        tflag_d   = tflag_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        frame_d   = frame_q;
        frame_inc = frame_q + 1'b1;
        case (state_q)
            ST_RUN: begin
                if (sel_s_q != src_sel_q) begin
                    state_d = ST_DRAIN;
                    mute_d  = 1'b1;
                    busy_d  = 1'b1;
                    timer_d = '0;
                    frame_d = '0;
                    tflag_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (sel_s_q == src_sel_q) begin
                    state_d = ST_RUN;
                    mute_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (cur_edge || timer_q == TMR_LAST) begin
                    // an edge coinciding with the timeout counts as a clean edge
                    state_d   = ST_MUTE;
                    src_sel_d = sel_s_q;
                    timer_d   = '0;
                    frame_d   = '0;
                    tflag_d   = !cur_edge;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_MUTE: begin
                if (sel_s_q != src_sel_q) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                    frame_d = '0;
                    tflag_d = 1'b0;
                end else if (frame_q == FRM_LAST || (cur_edge && frame_inc == FRM_LAST)) begin
                    state_d = ST_RUN;
                    mute_d  = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                end else if (cur_edge) begin
                    frame_d = frame_inc;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_RUN;
                    mute_d  = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    tflag_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        vg_reset_d = (state_d == ST_RUN) && src_sel_d;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sel_s_q    <= 1'b0;
            state_q    <= ST_RUN;
            src_sel_q  <= 1'b0;
            mute_q     <= 1'b0;
            busy_q     <= 1'b0;
            vg_reset_q <= 1'b0;
            tflag_q    <= 1'b0;
            cnt_q      <= '0;
            timer_q    <= '0;
            frame_q    <= '0;
        end else begin
            sync1_q    <= sel_req;
            sel_s_q    <= sync1_q;
            state_q    <= state_d;
            src_sel_q  <= src_sel_d;
            mute_q     <= mute_d;
            busy_q     <= busy_d;
            vg_reset_q <= vg_reset_d;
            tflag_q    <= tflag_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            frame_q    <= frame_d;
        end
    end

    assign src_sel      = src_sel_q;
    assign mute         = mute_q;
    assign busy         = busy_q;
    assign vg_reset     = vg_reset_q;
    assign timeout_flag = tflag_q;
    assign switch_cnt   = cnt_q;

endmodule

// File: tb/tb_out_src_seq.sv
// Bench for out_src_seq: stimulus queues cycle-stamped expected output changes,
// a monitor compares every observed output change and snapshot against them.
module tb_out_src_seq;

    typedef struct {
        int          cyc;
        logic [12:0] val;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_req = 1'b0;
    logic       vs_sc = 1'b1;
    logic       vs_vg = 1'b1;
    logic       src_sel, mute, vg_reset, busy, timeout_flag;
    logic [7:0] switch_cnt;

    int          cyc = 0;
    exp_t        chg_q[$];
    exp_t        snap_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic        end_req = 1'b0;
    logic        end_done = 1'b0;
    logic [12:0] mon_last = '0;
    logic [12:0] mon_cur;
    logic [7:0]  exp_cnt = '0;

    out_src_seq #(.MUTE_FRAMES(2), .VS_TIMEOUT(1000), .VS_ACTIVE(1'b0)) dut (
        .pclk(clk), .reset(rst), .sel_req(sel_req), .vsync_sc(vs_sc), .vsync_vg(vs_vg),
        .src_sel(src_sel), .mute(mute), .vg_reset(vg_reset), .busy(busy),
        .timeout_flag(timeout_flag), .switch_cnt(switch_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] pk(input logic s, input logic m, input logic b,
                                       input logic v, input logic t, input logic [7:0] n);
        return {s, m, b, v, t, n};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_chg(input int at, input logic [12:0] v, input string nm);
        chg_q.push_back(exp_t'{cyc: at, val: v, name: nm});
    endtask

    task automatic exp_snap(input int at, input logic [12:0] v, input string nm);
        snap_q.push_back(exp_t'{cyc: at, val: v, name: nm});
    endtask

    task automatic set_vs(input logic src, input logic lvl);
        if (src) vs_sc = lvl;
        else     vs_vg = lvl;
    endtask

    // Full switch: drain on one old-source edge, then two new-source edges.
    task automatic do_switch(input logic to);
        logic from;
        int   c;
        from = ~to;
        sel_req = to;
        c = cyc;
        exp_chg(c + 3, pk(from, 1, 1, 0, 0, exp_cnt), "drain_entry");
        tick(5);
        set_vs(from, 1'b0);
        exp_chg(cyc + 1, pk(to, 1, 1, 0, 0, exp_cnt), "src_flip");
        tick(1); set_vs(from, 1'b1); tick(2);
        set_vs(to, 1'b0); tick(1); set_vs(to, 1'b1); tick(2);
        exp_cnt = exp_cnt + 8'd1;
        set_vs(to, 1'b0);
        exp_chg(cyc + 1, pk(to, 0, 0, to, 0, exp_cnt), "switch_done");
        tick(1); set_vs(to, 1'b1); tick(2);
    endtask

    // Monitor: every output change must match the next queued change at its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_cur = {src_sel, mute, busy, vg_reset, timeout_flag, switch_cnt};
                if (mon_cur !== mon_last) begin
                    n_tests++;
                    if (chg_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_change: got %h at cyc %0d, want no change (%h)",
                                 mon_cur, cyc, mon_last);
                    end else begin
                        e = chg_q.pop_front();
                        if (e.val !== mon_cur || e.cyc != cyc) begin
                            n_fail++;
                            $display("FAIL %s: got %h at cyc %0d, want %h at cyc %0d",
                                     e.name, mon_cur, cyc, e.val, e.cyc);
                        end
                    end
                end
                if (snap_q.size() != 0 && snap_q[0].cyc == cyc) begin
                    e = snap_q.pop_front();
                    n_tests++;
                    if (mon_cur !== e.val) begin
                        n_fail++;
                        $display("FAIL %s: got %h, want %h at cyc %0d", e.name, mon_cur, e.val, cyc);
                    end
                end
                mon_last = mon_cur;
            end
            if (end_req && !end_done) begin
                n_tests++;
                if (chg_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_change: got %0d left (first %s due cyc %0d), want 0",
                             chg_q.size(), chg_q[0].name, chg_q[0].cyc);
                end
                if (snap_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_snapshot: got %0d left, want 0", snap_q.size());
                end
                end_done = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        tick(3);
        mon_last = '0;
        rst = 1'b0;
        mon_en = 1'b1;

        // quiet after reset
        exp_snap(cyc + 1, 13'h0, "reset_state");
        tick(5000);
        exp_snap(cyc + 1, 13'h0, "idle_5000");
        tick(3);

        // normal switches both ways
        do_switch(1'b1);
        tick(4);
        do_switch(1'b0);
        tick(4);

        // request withdrawn while draining
        sel_req = 1'b1;
        c = cyc;
        exp_chg(c + 3, pk(0, 1, 1, 0, 0, exp_cnt), "withdraw_drain");
        tick(10);
        sel_req = 1'b0;
        exp_chg(c + 13, pk(0, 0, 0, 0, 0, exp_cnt), "withdraw_run");
        tick(16);

        // no vsync at all: DRAIN and MUTE both time out
        sel_req = 1'b1;
        c = cyc;
        exp_chg(c + 3, pk(0, 1, 1, 0, 0, exp_cnt), "to_drain_entry");
        exp_chg(c + 1003, pk(1, 1, 1, 0, 1, exp_cnt), "to_drain_timeout");
        exp_chg(c + 2003, pk(1, 0, 0, 1, 1, exp_cnt + 8'd1), "to_mute_timeout");
        exp_cnt = exp_cnt + 8'd1;
        tick(2010);

        // old-source edge on the exact timeout cycle wins, flag stays clear
        sel_req = 1'b0;
        c = cyc;
        exp_chg(c + 3, pk(1, 1, 1, 0, 0, exp_cnt), "coin_drain_entry");
        tick(1002);
        set_vs(1'b1, 1'b0);
        exp_chg(cyc + 1, pk(0, 1, 1, 0, 0, exp_cnt), "coin_edge_wins");
        tick(1); set_vs(1'b1, 1'b1); tick(2);
        set_vs(1'b0, 1'b0); tick(1); set_vs(1'b0, 1'b1); tick(2);
        exp_cnt = exp_cnt + 8'd1;
        set_vs(1'b0, 1'b0);
        exp_chg(cyc + 1, pk(0, 0, 0, 0, 0, exp_cnt), "coin_done");
        tick(1); set_vs(1'b0, 1'b1); tick(4);

        // asynchronous reset in the middle of MUTE
        sel_req = 1'b1;
        c = cyc;
        exp_chg(c + 3, pk(0, 1, 1, 0, 0, exp_cnt), "rst_drain_entry");
        tick(5);
        set_vs(1'b0, 1'b0);
        exp_chg(cyc + 1, pk(1, 1, 1, 0, 0, exp_cnt), "rst_src_flip");
        tick(1); set_vs(1'b0, 1'b1); tick(3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sel_req = 1'b0;
        exp_cnt = '0;
        exp_chg(cyc, 13'h0, "async_reset");
        tick(4);
        rst = 1'b0;
        tick(4);

        // 256 switches: the last one wraps the counter 255 -> 0
        for (int i = 0; i < 256; i++) begin
            do_switch((i % 2) == 0);
        end
        tick(4);

        end_req = 1'b1;
        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
